// File: rtl/pc_cfr_cpg_allocator.sv
//------------------------------------------------------------------------------
// pc_cfr_cpg_allocator
//
// Shares a pool of cancellation pulse generators (CPGs) between the peaks
// found by the peak detector. Each accepted peak claims the lowest-index
// free CPG. That CPG then runs one full pulse: it walks the CPW RAM address
// from 0 to 2**CPW_ADDR_WIDTH-1 and holds the peak scale constant for the
// whole pulse. A peak that finds no free CPG is dropped and counted.
//
// Ports:
//   clk            datapath clock
//   rst_n          asynchronous active-low reset
//   enable         accept new peaks when 1
//   peak_valid     one-cycle strobe, peak detected this cycle
//   peak_scale_i/q signed I/Q scale of the peak
//   cnt_clear      synchronous clear of drop_count
//   cpg_start      one-cycle start strobe per CPG
//   cpg_active     CPG k is emitting a pulse
//   cpg_addr       CPW read address per CPG, packed [k*CPW_ADDR_WIDTH +: CPW_ADDR_WIDTH]
//   cpg_scale_i/q  scale per CPG, packed [k*DATA_WIDTH +: DATA_WIDTH]
//   peak_accepted  one-cycle strobe, peak allocated
//   peak_dropped   one-cycle strobe, peak dropped (no free CPG)
//   drop_count     saturating count of dropped peaks
//
// Per-CPG state machine:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no pulse; addr and scale held at 0
//   ST_RUN  | emitting a pulse; addr advances by 1 each cycle from 0
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pc_cfr_cpg_allocator #(
  parameter int DATA_WIDTH     = 16,
  parameter int CPW_ADDR_WIDTH = 8,
  parameter int NUM_CPG        = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                peak_valid,
  input  logic [DATA_WIDTH-1:0]               peak_scale_i,
  input  logic [DATA_WIDTH-1:0]               peak_scale_q,
  input  logic                                cnt_clear,
  output logic [NUM_CPG-1:0]                  cpg_start,
  output logic [NUM_CPG-1:0]                  cpg_active,
  output logic [NUM_CPG*CPW_ADDR_WIDTH-1:0]   cpg_addr,
  output logic [NUM_CPG*DATA_WIDTH-1:0]       cpg_scale_i,
  output logic [NUM_CPG*DATA_WIDTH-1:0]       cpg_scale_q,
  output logic                                peak_accepted,
  output logic                                peak_dropped,
  output logic [CNT_WIDTH-1:0]                drop_count
);

  localparam logic [CPW_ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX   = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cpg_state_t;

  cpg_state_t                state   [NUM_CPG];
  logic [CPW_ADDR_WIDTH-1:0] addr_r  [NUM_CPG];
  logic [DATA_WIDTH-1:0]     scale_i_r [NUM_CPG];
  logic [DATA_WIDTH-1:0]     scale_q_r [NUM_CPG];

  logic [NUM_CPG-1:0] cpg_free;
  logic [NUM_CPG-1:0] sel_onehot;
  logic               any_free;
  logic               peak_req;
  logic               do_alloc;
  logic               do_drop;

  // A CPG on its last sample counts as free so a new pulse can follow it
  // with no idle cycle in between.
  always_comb begin
    cpg_free   = '0;
    sel_onehot = '0;
    any_free   = 1'b0;
    for (int k = 0; k < NUM_CPG; k++) begin
      cpg_free[k] = (state[k] == ST_IDLE) || (addr_r[k] == ADDR_LAST);
      if (cpg_free[k] && !any_free) begin
        sel_onehot[k] = 1'b1;
        any_free      = 1'b1;
      end
    end
  end

  assign peak_req = peak_valid && enable;
  assign do_alloc = peak_req && any_free;
  assign do_drop  = peak_req && !any_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CPG; k++) begin
        state[k]     <= ST_IDLE;
        addr_r[k]    <= '0;
        scale_i_r[k] <= '0;
        scale_q_r[k] <= '0;
      end
      cpg_start     <= '0;
      peak_accepted <= 1'b0;
      peak_dropped  <= 1'b0;
      drop_count    <= '0;
    end else begin
      for (int k = 0; k < NUM_CPG; k++) begin
        if (do_alloc && sel_onehot[k]) begin
          state[k]     <= ST_RUN;
          addr_r[k]    <= '0;
          scale_i_r[k] <= peak_scale_i;
          scale_q_r[k] <= peak_scale_q;
        end else if (state[k] == ST_RUN) begin
          if (addr_r[k] == ADDR_LAST) begin
            state[k]     <= ST_IDLE;
            addr_r[k]    <= '0;
            scale_i_r[k] <= '0;
            scale_q_r[k] <= '0;
          end else begin
            addr_r[k] <= addr_r[k] + 1'b1;
          end
        end
      end

      cpg_start     <= do_alloc ? sel_onehot : '0;
      peak_accepted <= do_alloc;
      peak_dropped  <= do_drop;

      // Clear takes priority over a coincident drop.
      if (cnt_clear) begin
        drop_count <= '0;
      end else if (do_drop && (drop_count != CNT_MAX)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CPG; k++) begin : g_pack
    assign cpg_active[k]                                    = (state[k] == ST_RUN);
    assign cpg_addr[k*CPW_ADDR_WIDTH +: CPW_ADDR_WIDTH]     = addr_r[k];
    assign cpg_scale_i[k*DATA_WIDTH +: DATA_WIDTH]          = scale_i_r[k];
    assign cpg_scale_q[k*DATA_WIDTH +: DATA_WIDTH]          = scale_q_r[k];
  end

endmodule

// File: tb/tb_pc_cfr_cpg_allocator.sv
`timescale 1ns/1ps

module tb_pc_cfr_cpg_allocator;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NC = 4;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              peak_valid;
  logic [DW-1:0]     peak_scale_i;
  logic [DW-1:0]     peak_scale_q;
  logic              cnt_clear;
  logic [NC-1:0]     cpg_start;
  logic [NC-1:0]     cpg_active;
  logic [NC*AW-1:0]  cpg_addr;
  logic [NC*DW-1:0]  cpg_scale_i;
  logic [NC*DW-1:0]  cpg_scale_q;
  logic              peak_accepted;
  logic              peak_dropped;
  logic [CW-1:0]     drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_cfr_cpg_allocator #(
    .DATA_WIDTH    (DW),
    .CPW_ADDR_WIDTH(AW),
    .NUM_CPG       (NC),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .peak_valid   (peak_valid),
    .peak_scale_i (peak_scale_i),
    .peak_scale_q (peak_scale_q),
    .cnt_clear    (cnt_clear),
    .cpg_start    (cpg_start),
    .cpg_active   (cpg_active),
    .cpg_addr     (cpg_addr),
    .cpg_scale_i  (cpg_scale_i),
    .cpg_scale_q  (cpg_scale_q),
    .peak_accepted(peak_accepted),
    .peak_dropped (peak_dropped),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " start"},    64'(cpg_start),     64'd0);
    chk({tag, " active"},   64'(cpg_active),    64'd0);
    chk({tag, " addr"},     64'(cpg_addr),      64'd0);
    chk({tag, " scale_i"},  cpg_scale_i,        64'd0);
    chk({tag, " scale_q"},  cpg_scale_q,        64'd0);
    chk({tag, " accepted"}, 64'(peak_accepted), 64'd0);
    chk({tag, " dropped"},  64'(peak_dropped),  64'd0);
    chk({tag, " count"},    64'(drop_count),    64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    peak_valid   = 1'b0;
    peak_scale_i = '0;
    peak_scale_q = '0;
    cnt_clear    = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Single peak (1000,-500): one full 8-sample pulse on CPG0
    peak_valid = 1'b1; peak_scale_i = 16'd1000; peak_scale_q = 16'hFE0C;
    tick();
    peak_valid = 1'b0;
    chk("p1 start",    64'(cpg_start),            64'h1);
    chk("p1 accepted", 64'(peak_accepted),        64'h1);
    chk("p1 active",   64'(cpg_active),           64'h1);
    chk("p1 addr0",    64'(cpg_addr[0 +: AW]),    64'h0);
    chk("p1 scale_i",  64'(cpg_scale_i[0 +: DW]), 64'd1000);
    chk("p1 scale_q",  64'(cpg_scale_q[0 +: DW]), 64'hFE0C);
    for (int a = 1; a < 8; a++) begin
      tick();
      chk("p1 run addr0",  64'(cpg_addr[0 +: AW]),    64'(a));
      chk("p1 run scale",  64'(cpg_scale_q[0 +: DW]), 64'hFE0C);
      chk("p1 run start",  64'(cpg_start),            64'h0);
    end
    tick();
    chk("p1 end active",  64'(cpg_active), 64'h0);
    chk("p1 end addr",    64'(cpg_addr),   64'h0);
    chk("p1 end scale_i", cpg_scale_i,     64'h0);
    chk("p1 end scale_q", cpg_scale_q,     64'h0);

    // Five consecutive peaks: four allocations in priority order, then a drop
    for (int i = 0; i < 4; i++) begin
      peak_valid = 1'b1; peak_scale_i = 16'(100 + i); peak_scale_q = 16'(200 + i);
      tick();
      chk("fill start",    64'(cpg_start),     64'(1 << i));
      chk("fill accepted", 64'(peak_accepted), 64'h1);
    end
    chk("fill scale2", 64'(cpg_scale_i[2*DW +: DW]), 64'd102);
    chk("fill addr0",  64'(cpg_addr[0 +: AW]),       64'd3);
    tick();
    peak_valid = 1'b0;
    chk("drop1 dropped",  64'(peak_dropped),  64'h1);
    chk("drop1 accepted", 64'(peak_accepted), 64'h0);
    chk("drop1 start",    64'(cpg_start),     64'h0);
    chk("drop1 count",    64'(drop_count),    64'd1);
    repeat (8) tick();
    chk("fill drained", 64'(cpg_active), 64'h0);

    // Back-to-back reuse of CPG0 when a peak lands on its last sample
    peak_valid = 1'b1; peak_scale_i = 16'd200; peak_scale_q = 16'd300;
    tick();
    peak_valid = 1'b0;
    chk("b2b first start", 64'(cpg_start), 64'h1);
    repeat (7) tick();
    chk("b2b addr7", 64'(cpg_addr[0 +: AW]), 64'd7);
    peak_valid = 1'b1; peak_scale_i = 16'd400; peak_scale_q = 16'd500;
    tick();
    peak_valid = 1'b0;
    chk("b2b restart start",  64'(cpg_start),            64'h1);
    chk("b2b restart active", 64'(cpg_active),           64'h1);
    chk("b2b restart addr",   64'(cpg_addr[0 +: AW]),    64'd0);
    chk("b2b restart scale",  64'(cpg_scale_i[0 +: DW]), 64'd400);
    repeat (8) tick();
    chk("b2b drained", 64'(cpg_active), 64'h0);

    // enable=0 ignores peaks but lets CPG1 finish its pulse
    peak_valid = 1'b1; peak_scale_i = 16'd11; peak_scale_q = 16'd22;
    tick();
    peak_scale_i = 16'd77; peak_scale_q = 16'd88;
    tick();
    chk("en cpg1 start", 64'(cpg_start), 64'h2);
    enable = 1'b0;
    tick();
    chk("en0 accepted", 64'(peak_accepted),     64'h0);
    chk("en0 dropped",  64'(peak_dropped),      64'h0);
    chk("en0 start",    64'(cpg_start),         64'h0);
    chk("en0 count",    64'(drop_count),        64'd1);
    chk("en0 addr1",    64'(cpg_addr[AW +: AW]), 64'd1);
    for (int a = 2; a < 8; a++) begin
      tick();
      chk("en0 addr1 run", 64'(cpg_addr[AW +: AW]), 64'(a));
      chk("en0 no accept", 64'(peak_accepted),      64'h0);
    end
    chk("en0 scale1", 64'(cpg_scale_i[DW +: DW]), 64'd77);
    tick();
    chk("en0 drained", 64'(cpg_active), 64'h0);
    peak_valid = 1'b0;
    enable     = 1'b1;

    // Drop counter saturation and clear priority
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clr count", 64'(drop_count), 64'd0);
    peak_valid = 1'b1; peak_scale_i = 16'd9; peak_scale_q = 16'd9;
    repeat (4) tick();
    chk("sat fill active", 64'(cpg_active), 64'hF);
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk("sat dropped", 64'(peak_dropped), 64'h1);
      chk("sat count",   64'(drop_count),   64'((d < 3) ? d : 3));
    end
    peak_valid = 1'b0;
    repeat (8) tick();
    chk("sat drained", 64'(cpg_active), 64'h0);
    peak_valid = 1'b1;
    repeat (4) tick();
    tick();
    chk("sat5 dropped", 64'(peak_dropped), 64'h1);
    chk("sat5 count",   64'(drop_count),   64'd3);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clr+drop dropped", 64'(peak_dropped), 64'h1);
    chk("clr+drop count",   64'(drop_count),   64'd0);
    tick();
    chk("post clr count", 64'(drop_count), 64'd1);
    peak_valid = 1'b0;

    // Asynchronous reset in the middle of running pulses
    chk("pre-rst addr0", 64'(cpg_addr[0 +: AW]), 64'd6);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post-rst active", 64'(cpg_active), 64'h0);
    peak_valid = 1'b1; peak_scale_i = 16'd5; peak_scale_q = 16'd6;
    tick();
    peak_valid = 1'b0;
    chk("post-rst start",    64'(cpg_start),     64'h1);
    chk("post-rst accepted", 64'(peak_accepted), 64'h1);
    chk("post-rst scale_q",  64'(cpg_scale_q[0 +: DW]), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
